mem_rob_arbiter: RTL and testbench
==================================

Name: mem_rob_arbiter

Overview:
Shares one mem_rob instance between NREQ independent read requesters.
- Arbitrates requests round-robin and forwards the winner's address on the ROB's CPU-side request port.
- Records the winner's index in an in-order tag FIFO and routes each in-order ROB response back to the requester that issued it.
- Tracks outstanding reads so the ROB never receives a request it would silently drop when full.

Parameters:
NREQ, 4, number of requesters (>=2)
AW, 8, address width
DW, 8, data width
ROB_N, 16, mem_rob depth N (power of two)
MAX_OUT, ROB_N-1, outstanding-read limit (usable ROB capacity); also the tag FIFO depth

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_vld  in  NREQ  per-requester read request valid
req_addr  in  NREQ*AW  per-requester address, slice i = requester i
req_rdy  out  NREQ  one-hot grant; request i accepted when req_vld[i]&req_rdy[i]
rsp_vld  out  NREQ  one-hot response valid, 1-cycle pulse
rsp_data  out  DW  response data, shared by all requesters
rob_read_req  out  1  to mem_rob cpu_read_req
rob_read_addr  out  AW  to mem_rob cpu_read_addr
rob_read_data  in  DW  from mem_rob cpu_read_data
rob_read_valid  in  1  from mem_rob cpu_read_valid
outstanding  out  clog2(MAX_OUT+1)  reads in flight
err_spurious  out  1  sticky: response arrived with tag FIFO empty

Behaviour:
- Reset, async on rstn low: outstanding=0, tag FIFO empty, RR pointer=0, err_spurious=0. All outputs 0: req_rdy, rsp_vld, rob_read_req. rsp_data=0.
- Request handshake: valid/ready. Requester holds req_vld and req_addr stable until granted. req_rdy is combinational from req_vld, pointer and credit. It never depends on rob_read_valid.
- Credit: can_issue = (outstanding < MAX_OUT). When !can_issue, req_rdy=0 and rob_read_req=0.
- Arbitration: the highest-priority asserting requester is the one at or after rr_ptr, searching upward with wrap. The grant is one-hot. rob_read_req=|grant. rob_read_addr = the granted slice, otherwise 0. On a grant, rr_ptr <= granted index+1 (mod NREQ). Otherwise rr_ptr holds.
- Issue latency: 0 cycles, combinational pass-through, same as mem_rob acceptance.
- Tag FIFO: push the granted index (width max(1,clog2(NREQ))) on every grant. Pop on rob_read_valid.
- Response routing, combinational:
  - rsp_vld[i] = rob_read_valid & FIFO non-empty & head tag==i.
  - rsp_data = rob_read_data when any rsp_vld, otherwise 0.
  - No backpressure: mem_rob retires unconditionally, so requesters must accept a response in the cycle it is presented.
- outstanding update: outstanding <= outstanding + grant_any - pop.
  - Simultaneous grant and pop leaves it unchanged.
  - A pop at outstanding==MAX_OUT frees a slot only from the next cycle; there is no same-cycle bypass.
- Response with tag FIFO empty: rsp_vld stays 0, no pop, outstanding stays 0, err_spurious <= 1. err_spurious clears only on reset.
- FIFO pointers wrap mod MAX_OUT using explicit compare-and-clear (MAX_OUT need not be a power of two). Credit makes FIFO overflow impossible; implementation carries an assertion on it.
- Reset mid-operation discards all in-flight tags. mem_rob must be reset in the same domain by the same rstn.

Decomposition:
- Package mem_rob_arb_pkg: req_idx_t typedef, cnt_t typedef, localparams derived from NREQ and MAX_OUT, and the function rr_next(ptr, req) that returns the one-hot grant.
- Sub-module rr_arbiter: NREQ-wide round-robin grant with pointer register and an enable input (can_issue).
- The tag FIFO and credit counter stay inline in the top module.

Test Plan:
1. Single requester 2 issues addr 0x10,0x11, mem returns id1 then id0 -> rsp_vld[2] pulses twice with data for 0x10 then 0x11; outstanding 0->2->0.
2. All four req_vld held high from reset for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rob_read_req high every cycle.
3. Requester 0 streams 20 requests, memory stalls -> 15 grants, then req_rdy=0 and outstanding=15. The first response re-enables issue on the following cycle.
4. At outstanding=15: response and new req_vld in the same cycle -> no grant that cycle, outstanding=14. Next cycle grant, outstanding=15.
5. Interleaved issue 3,1,3,0, memory responds out of order -> rsp_vld one-hot sequence 3,1,3,0 with matching data.
6. Drive rob_read_valid with no issues -> no rsp_vld, err_spurious=1. Then assert rstn low mid-traffic with 5 outstanding -> all outputs 0, outstanding=0, err_spurious=0.

Source files
------------

// File: rtl/mem_rob_arb_pkg.sv
// Shared configuration, types and round-robin helpers for the mem_rob arbiter.
// The localparams here fix the configuration that the sub-blocks are sized for.
package mem_rob_arb_pkg;

    localparam int ARB_NREQ    = 4;
    localparam int ARB_AW      = 8;
    localparam int ARB_DW      = 8;
    localparam int ARB_ROB_N   = 16;
    localparam int ARB_MAX_OUT = ARB_ROB_N - 1;

    localparam int IDX_W  = (ARB_NREQ > 1) ? $clog2(ARB_NREQ) : 1;
    localparam int CNT_W  = $clog2(ARB_MAX_OUT + 1);
    localparam int FPTR_W = (ARB_MAX_OUT > 1) ? $clog2(ARB_MAX_OUT) : 1;

    typedef logic [IDX_W-1:0]    req_idx_t;
    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [FPTR_W-1:0]   fptr_t;
    typedef logic [ARB_NREQ-1:0] req_vec_t;

    // One-hot grant: first asserted request at or after ptr, wrapping upward.
    function automatic req_vec_t rr_next(input req_idx_t ptr, input req_vec_t req);
        req_vec_t g;
        logic     found;
        int       idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < ARB_NREQ; k++) begin
            idx = (int'(ptr) + k) % ARB_NREQ;
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic req_idx_t onehot_to_idx(input req_vec_t oh);
        req_idx_t r;
        r = '0;
        for (int k = 0; k < ARB_NREQ; k++) begin
            if (oh[k]) r = req_idx_t'(k);
        end
        return r;
    endfunction

    function automatic req_idx_t idx_inc(input req_idx_t i);
        return (int'(i) == ARB_NREQ - 1) ? '0 : i + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/mem_rob_arbiter_rr_arbiter.sv
// Round-robin grant generator with its priority pointer; the grant is
// suppressed entirely while en is low.
module rr_arbiter
    import mem_rob_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [ARB_NREQ-1:0] req,
    output logic [ARB_NREQ-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_any
);

    req_idx_t ptr;

    always_comb begin
        grant     = en ? rr_next(ptr, req) : '0;
        grant_idx = onehot_to_idx(grant);
        grant_any = |grant;
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= idx_inc(grant_idx);
        end
    end

endmodule

// File: rtl/mem_rob_arbiter.sv
// Shares one mem_rob among NREQ read requesters: round-robin issue with credit
// limiting, and an in-order tag FIFO that steers each response to its owner.
module mem_rob_arbiter
    import mem_rob_arb_pkg::*;
#(
    parameter int NREQ    = ARB_NREQ,
    parameter int AW      = ARB_AW,
    parameter int DW      = ARB_DW,
    parameter int ROB_N   = ARB_ROB_N,
    parameter int MAX_OUT = ROB_N - 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NREQ-1:0]              req_vld,
    input  logic [NREQ*AW-1:0]           req_addr,
    output logic [NREQ-1:0]              req_rdy,
    output logic [NREQ-1:0]              rsp_vld,
    output logic [DW-1:0]                rsp_data,
    output logic                         rob_read_req,
    output logic [AW-1:0]                rob_read_addr,
    input  logic [DW-1:0]                rob_read_data,
    input  logic                         rob_read_valid,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         err_spurious
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic           can_issue;
    logic [NREQ-1:0] grant;
    req_idx_t       grant_idx;
    logic           grant_any;

    req_idx_t       tag_mem [MAX_OUT];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           fifo_empty;
    logic           pop;
    req_idx_t       head_tag;

    // Reset gating keeps every handshake output low while rstn is asserted.
    assign can_issue = rstn && (outstanding < OW'(MAX_OUT));

    rr_arbiter u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .en        (can_issue),
        .req       (req_vld),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_rdy      = grant;
    assign rob_read_req = grant_any;

    always_comb begin
        rob_read_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) rob_read_addr = req_addr[i*AW +: AW];
        end
    end

    // FIFO occupancy is exactly the in-flight count, so outstanding doubles as it.
    assign fifo_empty = (outstanding == '0);
    assign pop        = rob_read_valid && !fifo_empty;
    assign head_tag   = tag_mem[rd_ptr];

    always_comb begin
        rsp_vld = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_vld[i] = pop && (head_tag == req_idx_t'(i));
        end
        rsp_data = pop ? rob_read_data : '0;
    end

    always_ff @(posedge clk) begin
        if (grant_any) tag_mem[wr_ptr] <= grant_idx;
    end

    // Pointers wrap by compare-and-clear since MAX_OUT is usually not a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            outstanding  <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (grant_any) begin
                wr_ptr <= (wr_ptr == PW'(MAX_OUT - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(MAX_OUT - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({grant_any, pop})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
            if (rob_read_valid && fifo_empty) err_spurious <= 1'b1;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rstn)
        grant_any |-> (outstanding < OW'(MAX_OUT)));

endmodule

// File: tb/tb_mem_rob_arbiter.sv
// Directed self-checking bench for mem_rob_arbiter; the bench plays the part
// of an in-order mem_rob, returning data = addr ^ 8'h5A in issue order.
module tb_mem_rob_arbiter;

    logic        clk;
    logic        rstn;
    logic [3:0]  req_vld;
    logic [31:0] req_addr;
    logic [3:0]  req_rdy;
    logic [3:0]  rsp_vld;
    logic [7:0]  rsp_data;
    logic        rob_read_req;
    logic [7:0]  rob_read_addr;
    logic [7:0]  rob_read_data;
    logic        rob_read_valid;
    logic [3:0]  outstanding;
    logic        err_spurious;

    int n_cmp;
    int n_bad;

    mem_rob_arbiter dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_vld        (req_vld),
        .req_addr       (req_addr),
        .req_rdy        (req_rdy),
        .rsp_vld        (rsp_vld),
        .rsp_data       (rsp_data),
        .rob_read_req   (rob_read_req),
        .rob_read_addr  (rob_read_addr),
        .rob_read_data  (rob_read_data),
        .rob_read_valid (rob_read_valid),
        .outstanding    (outstanding),
        .err_spurious   (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_data(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn           = 1'b0;
        req_vld        = 4'hF;
        req_addr       = 32'h43424140;
        rob_read_valid = 1'b1;
        rob_read_data  = 8'hEE;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (req_rdy !== 4'b0000) begin n_bad++; $display("[TB] FAIL rst_rdy: got %b want 0000", req_rdy); end
        n_cmp++; if (rsp_vld !== 4'b0000) begin n_bad++; $display("[TB] FAIL rst_rsp_vld: got %b want 0000", rsp_vld); end
        n_cmp++; if (rob_read_req !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_rob_req: got %b want 0", rob_read_req); end
        n_cmp++; if (rob_read_addr !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_rob_addr: got %h want 00", rob_read_addr); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_rsp_data: got %h want 00", rsp_data); end
        n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("[TB] FAIL rst_outstanding: got %0d want 0", outstanding); end
        n_cmp++; if (err_spurious !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_err: got %b want 0", err_spurious); end
        req_vld        = 4'h0;
        rob_read_valid = 1'b0;
        rob_read_data  = 8'h00;
        next_cycle();
        rstn = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        req_addr = 32'h43424140;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            req_vld = 4'hF;
            #1;
            exp_oh = 4'b0001 << (k % 4);
            n_cmp++; if (req_rdy !== exp_oh) begin n_bad++; $display("[TB] FAIL rr_grant%0d: got %b want %b", k, req_rdy, exp_oh); end
            n_cmp++; if (rob_read_req !== 1'b1) begin n_bad++; $display("[TB] FAIL rr_req%0d: got %b want 1", k, rob_read_req); end
            n_cmp++; if (rob_read_addr !== 8'(8'h40 + k % 4)) begin n_bad++; $display("[TB] FAIL rr_addr%0d: got %h want %h", k, rob_read_addr, 8'(8'h40 + k % 4)); end
        end
        next_cycle();
        req_vld = 4'h0;
        n_cmp++; if (outstanding !== 4'd8) begin n_bad++; $display("[TB] FAIL rr_out8: got %0d want 8", outstanding); end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cycle();
            rob_read_valid = 1'b1;
            rob_read_data  = mem_data(8'(8'h40 + k % 4));
            #1;
            exp_oh = 4'b0001 << (k % 4);
            n_cmp++; if (rsp_vld !== exp_oh) begin n_bad++; $display("[TB] FAIL rr_rsp%0d: got %b want %b", k, rsp_vld, exp_oh); end
            n_cmp++; if (rsp_data !== mem_data(8'(8'h40 + k % 4))) begin n_bad++; $display("[TB] FAIL rr_data%0d: got %h want %h", k, rsp_data, mem_data(8'(8'h40 + k % 4))); end
        end
        next_cycle();
        rob_read_valid = 1'b0;
        n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("[TB] FAIL rr_out0: got %0d want 0", outstanding); end
    endtask

    task automatic test_single();
        next_cycle();
        req_vld = 4'b0100;
        req_addr[23:16] = 8'h10;
        #1;
        n_cmp++; if (req_rdy !== 4'b0100) begin n_bad++; $display("[TB] FAIL s_rdy0: got %b want 0100", req_rdy); end
        n_cmp++; if (rob_read_addr !== 8'h10) begin n_bad++; $display("[TB] FAIL s_addr0: got %h want 10", rob_read_addr); end
        next_cycle();
        n_cmp++; if (outstanding !== 4'd1) begin n_bad++; $display("[TB] FAIL s_out1: got %0d want 1", outstanding); end
        req_addr[23:16] = 8'h11;
        #1;
        n_cmp++; if (req_rdy !== 4'b0100) begin n_bad++; $display("[TB] FAIL s_rdy1: got %b want 0100", req_rdy); end
        n_cmp++; if (rob_read_addr !== 8'h11) begin n_bad++; $display("[TB] FAIL s_addr1: got %h want 11", rob_read_addr); end
        next_cycle();
        req_vld = 4'b0000;
        n_cmp++; if (outstanding !== 4'd2) begin n_bad++; $display("[TB] FAIL s_out2: got %0d want 2", outstanding); end
        rob_read_valid = 1'b1;
        rob_read_data  = mem_data(8'h10);
        #1;
        n_cmp++; if (rsp_vld !== 4'b0100) begin n_bad++; $display("[TB] FAIL s_rsp0: got %b want 0100", rsp_vld); end
        n_cmp++; if (rsp_data !== mem_data(8'h10)) begin n_bad++; $display("[TB] FAIL s_data0: got %h want %h", rsp_data, mem_data(8'h10)); end
        next_cycle();
        rob_read_data = mem_data(8'h11);
        #1;
        n_cmp++; if (rsp_vld !== 4'b0100) begin n_bad++; $display("[TB] FAIL s_rsp1: got %b want 0100", rsp_vld); end
        n_cmp++; if (rsp_data !== mem_data(8'h11)) begin n_bad++; $display("[TB] FAIL s_data1: got %h want %h", rsp_data, mem_data(8'h11)); end
        next_cycle();
        rob_read_valid = 1'b0;
        #1;
        n_cmp++; if (rsp_vld !== 4'b0000) begin n_bad++; $display("[TB] FAIL s_rsp_idle: got %b want 0000", rsp_vld); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("[TB] FAIL s_data_idle: got %h want 00", rsp_data); end
        n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("[TB] FAIL s_out0: got %0d want 0", outstanding); end
    endtask

    task automatic test_credit_limit();
        logic [3:0] exp_rdy;
        logic [7:0] exp_addr;
        int         g;
        g = 0;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            req_vld = 4'b0001;
            req_addr[7:0] = 8'(8'h20 + g);
            #1;
            exp_rdy  = (k < 15) ? 4'b0001 : 4'b0000;
            exp_addr = (k < 15) ? 8'(8'h20 + k) : 8'h00;
            n_cmp++; if (req_rdy !== exp_rdy) begin n_bad++; $display("[TB] FAIL cr_rdy%0d: got %b want %b", k, req_rdy, exp_rdy); end
            n_cmp++; if (rob_read_addr !== exp_addr) begin n_bad++; $display("[TB] FAIL cr_addr%0d: got %h want %h", k, rob_read_addr, exp_addr); end
            if (k < 15) g++;
        end
        next_cycle();
        n_cmp++; if (outstanding !== 4'd15) begin n_bad++; $display("[TB] FAIL cr_out15: got %0d want 15", outstanding); end
        rob_read_valid = 1'b1;
        rob_read_data  = mem_data(8'h20);
        #1;
        n_cmp++; if (req_rdy !== 4'b0000) begin n_bad++; $display("[TB] FAIL cr_nobypass_rdy: got %b want 0000", req_rdy); end
        n_cmp++; if (rob_read_req !== 1'b0) begin n_bad++; $display("[TB] FAIL cr_nobypass_req: got %b want 0", rob_read_req); end
        n_cmp++; if (rsp_vld !== 4'b0001) begin n_bad++; $display("[TB] FAIL cr_rsp_first: got %b want 0001", rsp_vld); end
        next_cycle();
        rob_read_valid = 1'b0;
        #1;
        n_cmp++; if (outstanding !== 4'd14) begin n_bad++; $display("[TB] FAIL cr_out14: got %0d want 14", outstanding); end
        n_cmp++; if (req_rdy !== 4'b0001) begin n_bad++; $display("[TB] FAIL cr_regrant: got %b want 0001", req_rdy); end
        n_cmp++; if (rob_read_addr !== 8'h2F) begin n_bad++; $display("[TB] FAIL cr_regrant_addr: got %h want 2f", rob_read_addr); end
        next_cycle();
        req_vld = 4'b0000;
        n_cmp++; if (outstanding !== 4'd15) begin n_bad++; $display("[TB] FAIL cr_out15b: got %0d want 15", outstanding); end
        for (int k = 1; k <= 15; k++) begin
            if (k > 1) next_cycle();
            rob_read_valid = 1'b1;
            rob_read_data  = mem_data(8'(8'h20 + k));
            #1;
            n_cmp++; if (rsp_vld !== 4'b0001 || rsp_data !== mem_data(8'(8'h20 + k))) begin n_bad++; $display("[TB] FAIL cr_drain%0d: got %b/%h want 0001/%h", k, rsp_vld, rsp_data, mem_data(8'(8'h20 + k))); end
        end
        next_cycle();
        rob_read_valid = 1'b0;
        n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("[TB] FAIL cr_out0: got %0d want 0", outstanding); end
    endtask

    task automatic test_interleave();
        logic [3:0] vec [4];
        logic [7:0] adr [4];
        int         slot [4];
        vec[0] = 4'b1000; vec[1] = 4'b0010; vec[2] = 4'b1000; vec[3] = 4'b0001;
        adr[0] = 8'h30;   adr[1] = 8'h31;   adr[2] = 8'h32;   adr[3] = 8'h33;
        slot[0] = 3;      slot[1] = 1;      slot[2] = 3;      slot[3] = 0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            req_vld = vec[k];
            req_addr[slot[k]*8 +: 8] = adr[k];
            #1;
            n_cmp++; if (req_rdy !== vec[k] || rob_read_addr !== adr[k]) begin n_bad++; $display("[TB] FAIL il_issue%0d: got %b/%h want %b/%h", k, req_rdy, rob_read_addr, vec[k], adr[k]); end
        end
        next_cycle();
        req_vld = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            rob_read_valid = 1'b1;
            rob_read_data  = mem_data(adr[k]);
            #1;
            n_cmp++; if (rsp_vld !== vec[k] || rsp_data !== mem_data(adr[k])) begin n_bad++; $display("[TB] FAIL il_rsp%0d: got %b/%h want %b/%h", k, rsp_vld, rsp_data, vec[k], mem_data(adr[k])); end
            next_cycle();
            rob_read_valid = 1'b0;
            #1;
            n_cmp++; if (rsp_vld !== 4'b0000) begin n_bad++; $display("[TB] FAIL il_gap%0d: got %b want 0000", k, rsp_vld); end
            next_cycle();
        end
        n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("[TB] FAIL il_out0: got %0d want 0", outstanding); end
    endtask

    task automatic test_spurious_and_reset();
        next_cycle();
        rob_read_valid = 1'b1;
        rob_read_data  = 8'h77;
        #1;
        n_cmp++; if (rsp_vld !== 4'b0000) begin n_bad++; $display("[TB] FAIL sp_rsp: got %b want 0000", rsp_vld); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("[TB] FAIL sp_data: got %h want 00", rsp_data); end
        next_cycle();
        rob_read_valid = 1'b0;
        n_cmp++; if (err_spurious !== 1'b1) begin n_bad++; $display("[TB] FAIL sp_err: got %b want 1", err_spurious); end
        n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("[TB] FAIL sp_out: got %0d want 0", outstanding); end
        req_addr = 32'h53525150;
        for (int k = 0; k < 5; k++) begin
            req_vld = 4'hF;
            next_cycle();
        end
        n_cmp++; if (outstanding !== 4'd5) begin n_bad++; $display("[TB] FAIL mr_out5: got %0d want 5", outstanding); end
        n_cmp++; if (err_spurious !== 1'b1) begin n_bad++; $display("[TB] FAIL mr_err_sticky: got %b want 1", err_spurious); end
        rob_read_valid = 1'b1;
        rob_read_data  = 8'h99;
        rstn = 1'b0;
        #1;
        n_cmp++; if (req_rdy !== 4'b0000 || rob_read_req !== 1'b0 || rob_read_addr !== 8'h00) begin n_bad++; $display("[TB] FAIL mr_issue_zero: got %b/%b/%h want 0000/0/00", req_rdy, rob_read_req, rob_read_addr); end
        n_cmp++; if (rsp_vld !== 4'b0000 || rsp_data !== 8'h00) begin n_bad++; $display("[TB] FAIL mr_rsp_zero: got %b/%h want 0000/00", rsp_vld, rsp_data); end
        n_cmp++; if (outstanding !== 4'd0) begin n_bad++; $display("[TB] FAIL mr_out0: got %0d want 0", outstanding); end
        n_cmp++; if (err_spurious !== 1'b0) begin n_bad++; $display("[TB] FAIL mr_err0: got %b want 0", err_spurious); end
        rob_read_valid = 1'b0;
        next_cycle();
        rstn = 1'b1;
        #1;
        n_cmp++; if (req_rdy !== 4'b0001) begin n_bad++; $display("[TB] FAIL mr_ptr_reset: got %b want 0001", req_rdy); end
        next_cycle();
        req_vld = 4'h0;
        n_cmp++; if (outstanding !== 4'd1) begin n_bad++; $display("[TB] FAIL mr_out1: got %0d want 1", outstanding); end
        rob_read_valid = 1'b1;
        rob_read_data  = mem_data(8'h50);
        #1;
        n_cmp++; if (rsp_vld !== 4'b0001 || rsp_data !== mem_data(8'h50)) begin n_bad++; $display("[TB] FAIL mr_rsp: got %b/%h want 0001/%h", rsp_vld, rsp_data, mem_data(8'h50)); end
        next_cycle();
        rob_read_valid = 1'b0;
        n_cmp++; if (outstanding !== 4'd0 || err_spurious !== 1'b0) begin n_bad++; $display("[TB] FAIL mr_final: got %0d/%b want 0/0", outstanding, err_spurious); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_credit_limit();
        test_interleave();
        test_spurious_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
